alu_selftest_seq: RTL and testbench
===================================

Name: alu_selftest_seq

Overview:
- Synthesizable ALU self-test sequencer: the driving/checking end of the ALU operand/control/result interface, in hardware.
- On a start request it walks a fixed vector table, drives i_op1/i_op2/i_alu_ctrl of an alu instance, samples o_result after a settle window, and compares it with the golden value.
- Reports pass/fail, error count and first-failure details.
- Used for power-on core self-test and as an FPGA bring-up aid alongside the execute stage.

Parameters:
- SETTLE_CYCLES, 1, cycles operands are held before the result is sampled; legal range 1..15.
- STOP_ON_FAIL, 0, 1 = end the run at the first mismatch; 0 = run all vectors and count errors.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start request; sampled only in IDLE or DONE
- o_op1  output  32  operand 1 to ALU i_op1
- o_op2  output  32  operand 2 to ALU i_op2
- o_alu_ctrl  output  4  control to ALU i_alu_ctrl; encodings from rtl/parameters.vh macros
- i_result  input  32  ALU o_result
- o_busy  output  1  high in DRIVE and CHECK
- o_done  output  1  high while in DONE
- o_pass  output  1  valid when o_done: 1 = zero mismatches
- o_err_count  output  5  number of mismatching vectors
- o_fail_idx  output  4  index of first mismatching vector
- o_fail_result  output  32  i_result captured at first mismatch

Behaviour:
- Reset: clk and rst_n follow the decision "one clock; reset is asynchronous and active-low". Assertion at any time, including mid-run, forces IDLE immediately and clears all outputs to 0. This includes o_alu_ctrl=4'b0000, index and settle counter.
- Vector table: internal localparam NUM_VEC=15 entries {ctrl, op1, op2, expected}, index 0..14:
  - 0 ADD 10,20 -> 30
  - 1 SUB 50,25 -> 25
  - 2 AND 15,3 -> 3
  - 3 OR 7,12 -> 15
  - 4 XOR 11,5 -> 14
  - 5 SRL 80,3 -> 10
  - 6 SLL 3,4 -> 48
  - 7 SRA 0xFFFFFFD0,2 -> 0xFFFFFFF4
  - 8 SLT 0xFFFFFFF6,0xFFFFFFEC -> 0
  - 9 SLTU 0xFFFFFFEC,10 -> 0
  - 10 EQ 10,10 -> 1
  - 11 EQ 10,20 -> 0
  - 12 GE 30,20 -> 1
  - 13 GEU 20,30 -> 0
  - 14 GEU 0xFFFFFF9C,30 -> 1
- Compare results are full 32-bit values; 1 means 32'd1.
- FSM states and transitions:
  - IDLE: outputs quiescent. i_start=1 clears index, err_count, fail_idx, fail_result and pass, then goes to DRIVE on the next edge.
  - DRIVE: o_op1/o_op2/o_alu_ctrl registered from table[index], stable for the whole state. The state lasts exactly SETTLE_CYCLES cycles, counted by a settle counter.
  - CHECK: one cycle. Samples i_result and compares with expected. On mismatch, err_count increments, saturating at 31. On the first mismatch only, fail_idx and fail_result are captured. Operands stay held through CHECK.
  - After CHECK, go to DONE if index==14, or if STOP_ON_FAIL=1 and a mismatch occurred. Otherwise increment index and return to DRIVE.
  - DONE: o_done=1, o_pass=(err_count==0), operands held at last vector. i_start=1 restarts exactly as from IDLE, clearing all status.
- Timing: the first DRIVE cycle follows the start edge. A full clean run takes NUM_VEC*(SETTLE_CYCLES+1) cycles in DRIVE/CHECK. o_done rises on the following cycle.
- i_start while o_busy=1 is ignored and has no effect on index or counters.
- i_start held high continuously from DONE restarts once per entry into DONE.
- o_pass is 0 outside DONE.
- Status outputs (o_err_count, o_fail_*) update only in CHECK.

Test Plan:
- Clean run: SETTLE_CYCLES=1, real alu connected, pulse i_start -> o_busy high for 30 cycles, then o_done=1, o_pass=1, o_err_count=0, o_fail_idx=0.
- Fault injection: bench overrides i_result to 0 during the vector-6 CHECK, STOP_ON_FAIL=0 -> run completes, o_pass=0, o_err_count=1, o_fail_idx=6, o_fail_result=0.
- Stop on fail: STOP_ON_FAIL=1, i_result forced to 32'hDEADBEEF at vector 2 -> o_done after 3 vectors (6 cycles), o_fail_idx=2, o_fail_result=32'hDEADBEEF, o_err_count=1.
- Settle window: SETTLE_CYCLES=3 -> each vector's operands held 4 cycles, sampled only on the 4th. The bench checks o_alu_ctrl=SRA and o_op1=32'hFFFFFFD0 stable across the window; total run 60 cycles.
- Reset mid-run: deassert rst_n asynchronously during vector 9 -> all outputs 0 immediately without waiting for a clock edge. After release, a new i_start runs cleanly from vector 0.
- Start while busy and restart: pulse i_start at vector 4 -> no restart. From DONE with a prior error, pulse i_start -> err_count cleared and clean run gives o_pass=1.

Source files
------------

// File: rtl/alu_selftest_seq.sv
// rtl/alu_selftest_seq.sv - ALU self-test sequencer: walks a golden vector table through an external ALU
module alu_selftest_seq #(
   parameter int unsigned SETTLE_CYCLES = 1,    // operand hold cycles before sampling, 1..15
   parameter bit          STOP_ON_FAIL  = 1'b0  // 1 = end run at first mismatch
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   output logic [31:0] o_op1,
   output logic [31:0] o_op2,
   output logic [3:0]  o_alu_ctrl,
   input  logic [31:0] i_result,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic [4:0]  o_err_count,
   output logic [3:0]  o_fail_idx,
   output logic [31:0] o_fail_result
);

   // ALU control encodings shared with the execute stage
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SRL  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_EQ   = 4'd10;
   localparam logic [3:0] ALU_GE   = 4'd11;
   localparam logic [3:0] ALU_GEU  = 4'd12;

   localparam int unsigned NUM_VEC     = 15;
   localparam logic [3:0]  LAST_IDX    = 4'(NUM_VEC - 1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [4:0]  ERR_MAX     = 5'd31;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Golden table entry packed as {ctrl[99:96], op1[95:64], op2[63:32], expected[31:0]}
   function automatic logic [99:0] vec_f(input logic [3:0] i);
      case (i)
         4'd0:    vec_f = {ALU_ADD,  32'd10,         32'd20,         32'd30};
         4'd1:    vec_f = {ALU_SUB,  32'd50,         32'd25,         32'd25};
         4'd2:    vec_f = {ALU_AND,  32'd15,         32'd3,          32'd3};
         4'd3:    vec_f = {ALU_OR,   32'd7,          32'd12,         32'd15};
         4'd4:    vec_f = {ALU_XOR,  32'd11,         32'd5,          32'd14};
         4'd5:    vec_f = {ALU_SRL,  32'd80,         32'd3,          32'd10};
         4'd6:    vec_f = {ALU_SLL,  32'd3,          32'd4,          32'd48};
         4'd7:    vec_f = {ALU_SRA,  32'hFFFF_FFD0,  32'd2,          32'hFFFF_FFF4};
         4'd8:    vec_f = {ALU_SLT,  32'hFFFF_FFF6,  32'hFFFF_FFEC,  32'd0};
         4'd9:    vec_f = {ALU_SLTU, 32'hFFFF_FFEC,  32'd10,         32'd0};
         4'd10:   vec_f = {ALU_EQ,   32'd10,         32'd10,         32'd1};
         4'd11:   vec_f = {ALU_EQ,   32'd10,         32'd20,         32'd0};
         4'd12:   vec_f = {ALU_GE,   32'd30,         32'd20,         32'd1};
         4'd13:   vec_f = {ALU_GEU,  32'd20,         32'd30,         32'd0};
         4'd14:   vec_f = {ALU_GEU,  32'hFFFF_FF9C,  32'd30,         32'd1};
         default: vec_f = '0;
      endcase
   endfunction

   logic [1:0]  state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  settle_q, settle_d;
   logic [4:0]  err_q, err_d;
   logic [3:0]  fidx_q, fidx_d;
   logic [31:0] fres_q, fres_d;
   logic        pass_q, pass_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [3:0]  ctrl_q, ctrl_d;

   logic [99:0] vec_cur;
   logic [99:0] vec_nxt;
   logic [99:0] vec_first;
   logic        mismatch;
   logic        run_end;

   assign vec_cur   = vec_f(idx_q);
   assign vec_nxt   = vec_f(idx_q + 4'd1);
   assign vec_first = vec_f(4'd0);
   assign mismatch  = (i_result != vec_cur[31:0]);
   assign run_end   = (idx_q == LAST_IDX) || (STOP_ON_FAIL && mismatch);

   // Sequencer next-state: start/restart, settle counting, result check and advance
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      err_d    = err_q;
      fidx_d   = fidx_q;
      fres_d   = fres_q;
      pass_d   = pass_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      ctrl_d   = ctrl_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_d  = S_DRIVE;
               idx_d    = 4'd0;
               settle_d = 4'd0;
               err_d    = 5'd0;
               fidx_d   = 4'd0;
               fres_d   = 32'd0;
               pass_d   = 1'b0;
               ctrl_d   = vec_first[99:96];
               op1_d    = vec_first[95:64];
               op2_d    = vec_first[63:32];
            end
         end
         S_DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = S_CHECK;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + 5'd1;
               end
               // an error count of zero means this is the first mismatch of the run
               if (err_q == 5'd0) begin
                  fidx_d = idx_q;
                  fres_d = i_result;
               end
            end
            if (run_end) begin
               state_d = S_DONE;
               pass_d  = !mismatch && (err_q == 5'd0);
            end else begin
               state_d  = S_DRIVE;
               idx_d    = idx_q + 4'd1;
               settle_d = 4'd0;
               ctrl_d   = vec_nxt[99:96];
               op1_d    = vec_nxt[95:64];
               op2_d    = vec_nxt[63:32];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything to quiescent zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         settle_q <= 4'd0;
         err_q    <= 5'd0;
         fidx_q   <= 4'd0;
         fres_q   <= 32'd0;
         pass_q   <= 1'b0;
         op1_q    <= 32'd0;
         op2_q    <= 32'd0;
         ctrl_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         err_q    <= err_d;
         fidx_q   <= fidx_d;
         fres_q   <= fres_d;
         pass_q   <= pass_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         ctrl_q   <= ctrl_d;
      end
   end

   assign o_op1         = op1_q;
   assign o_op2         = op2_q;
   assign o_alu_ctrl    = ctrl_q;
   assign o_busy        = (state_q == S_DRIVE) || (state_q == S_CHECK);
   assign o_done        = (state_q == S_DONE);
   assign o_pass        = pass_q;
   assign o_err_count   = err_q;
   assign o_fail_idx    = fidx_q;
   assign o_fail_result = fres_q;

endmodule

// File: tb/tb_alu_selftest_seq.sv
// tb/tb_alu_selftest_seq.sv - scoreboard bench for alu_selftest_seq with a behavioural ALU
module tb_alu_selftest_seq;

   localparam logic [3:0] C_ADD  = 4'd0;
   localparam logic [3:0] C_SUB  = 4'd1;
   localparam logic [3:0] C_AND  = 4'd2;
   localparam logic [3:0] C_OR   = 4'd3;
   localparam logic [3:0] C_XOR  = 4'd4;
   localparam logic [3:0] C_SRL  = 4'd5;
   localparam logic [3:0] C_SLL  = 4'd6;
   localparam logic [3:0] C_SRA  = 4'd7;
   localparam logic [3:0] C_SLT  = 4'd8;
   localparam logic [3:0] C_SLTU = 4'd9;
   localparam logic [3:0] C_EQ   = 4'd10;
   localparam logic [3:0] C_GE   = 4'd11;
   localparam logic [3:0] C_GEU  = 4'd12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_w  [3];
   logic [31:0] op1_w    [3];
   logic [31:0] op2_w    [3];
   logic [3:0]  ctrl_w   [3];
   logic [31:0] res_w    [3];
   logic        busy_w   [3];
   logic        done_w   [3];
   logic        pass_w   [3];
   logic [4:0]  err_w    [3];
   logic [3:0]  fidx_w   [3];
   logic [31:0] fres_w   [3];

   // fault injection: replace the ALU result while a given vector is on the bus
   logic        fm_en    [3];
   int          fm_k     [3];
   logic [31:0] fm_val   [3];
   logic        man_on   [3];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          dut;
      logic        pass;
      logic [4:0]  err;
      logic [3:0]  fidx;
      logic [31:0] fres;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   alu_selftest_seq #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .i_start(start_w[0]),
      .o_op1(op1_w[0]), .o_op2(op2_w[0]), .o_alu_ctrl(ctrl_w[0]), .i_result(res_w[0]),
      .o_busy(busy_w[0]), .o_done(done_w[0]), .o_pass(pass_w[0]),
      .o_err_count(err_w[0]), .o_fail_idx(fidx_w[0]), .o_fail_result(fres_w[0]));

   alu_selftest_seq #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .i_start(start_w[1]),
      .o_op1(op1_w[1]), .o_op2(op2_w[1]), .o_alu_ctrl(ctrl_w[1]), .i_result(res_w[1]),
      .o_busy(busy_w[1]), .o_done(done_w[1]), .o_pass(pass_w[1]),
      .o_err_count(err_w[1]), .o_fail_idx(fidx_w[1]), .o_fail_result(fres_w[1]));

   alu_selftest_seq #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .i_start(start_w[2]),
      .o_op1(op1_w[2]), .o_op2(op2_w[2]), .o_alu_ctrl(ctrl_w[2]), .i_result(res_w[2]),
      .o_busy(busy_w[2]), .o_done(done_w[2]), .o_pass(pass_w[2]),
      .o_err_count(err_w[2]), .o_fail_idx(fidx_w[2]), .o_fail_result(fres_w[2]));

   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         C_ADD:   alu_f = a + b;
         C_SUB:   alu_f = a - b;
         C_AND:   alu_f = a & b;
         C_OR:    alu_f = a | b;
         C_XOR:   alu_f = a ^ b;
         C_SRL:   alu_f = a >> b[4:0];
         C_SLL:   alu_f = a << b[4:0];
         C_SRA:   alu_f = $unsigned($signed(a) >>> b[4:0]);
         C_SLT:   alu_f = {31'd0, $signed(a) < $signed(b)};
         C_SLTU:  alu_f = {31'd0, a < b};
         C_EQ:    alu_f = {31'd0, a == b};
         C_GE:    alu_f = {31'd0, $signed(a) >= $signed(b)};
         C_GEU:   alu_f = {31'd0, a >= b};
         default: alu_f = 32'd0;
      endcase
   endfunction

   // hand-copied {ctrl, op1, op2} of the vectors the bench needs to recognise
   function automatic logic [67:0] tvec(input int k);
      case (k)
         2:       tvec = {C_AND,  32'd15,        32'd3};
         4:       tvec = {C_XOR,  32'd11,        32'd5};
         6:       tvec = {C_SLL,  32'd3,         32'd4};
         7:       tvec = {C_SRA,  32'hFFFF_FFD0, 32'd2};
         9:       tvec = {C_SLTU, 32'hFFFF_FFEC, 32'd10};
         default: tvec = '1;
      endcase
   endfunction

   always_comb begin
      for (int d = 0; d < 3; d++) begin
         res_w[d] = man_on[d] ? 32'd0 :
                    (fm_en[d] && busy_w[d] && ({ctrl_w[d], op1_w[d], op2_w[d]} == tvec(fm_k[d]))) ? fm_val[d] :
                    alu_f(ctrl_w[d], op1_w[d], op2_w[d]);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // monitor: count busy cycles, pop the scoreboard on every rising o_done
   logic done_p [3] = '{1'b0, 1'b0, 1'b0};
   logic busy_p [3] = '{1'b0, 1'b0, 1'b0};
   int   cyc    [3] = '{0, 0, 0};
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (busy_w[d]) cyc[d] = busy_p[d] ? cyc[d] + 1 : 1;
         if (!done_w[d]) chk("pass_low_outside_done", 32'(pass_w[d]), 32'd0);
         if (done_w[d] && !done_p[d]) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(d), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_dut", 32'(d), 32'(e.dut));
               chk("sb_pass", 32'(pass_w[d]), 32'(e.pass));
               chk("sb_err_count", 32'(err_w[d]), 32'(e.err));
               chk("sb_fail_idx", 32'(fidx_w[d]), 32'(e.fidx));
               chk("sb_fail_result", fres_w[d], e.fres);
               chk("sb_busy_cycles", 32'(cyc[d]), 32'(e.cyc));
            end
         end
         done_p[d] = done_w[d];
         busy_p[d] = busy_w[d];
      end
   end

   task automatic push(input int d, input logic p, input logic [4:0] e, input logic [3:0] fi,
                       input logic [31:0] fr, input int c);
      exp_t x;
      x.dut = d; x.pass = p; x.err = e; x.fidx = fi; x.fres = fr; x.cyc = c;
      sb.push_back(x);
   endtask

   task automatic pulse_start(input int d);
      start_w[d] = 1'b1;
      @(posedge clk); #1;
      start_w[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget);
      int n = 0;
      while (!done_w[d] && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_within_budget", 32'(done_w[d]), 32'd1);
   endtask

   task automatic wait_vec(input int d, input int k, input int budget);
      int n = 0;
      while (({ctrl_w[d], op1_w[d], op2_w[d]} != tvec(k)) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("vector_reached", 32'({ctrl_w[d], op1_w[d], op2_w[d]} == tvec(k)), 32'd1);
   endtask

   task automatic chk_zero(input int d);
      chk("zero_op1", op1_w[d], 32'd0);
      chk("zero_op2", op2_w[d], 32'd0);
      chk("zero_ctrl", 32'(ctrl_w[d]), 32'd0);
      chk("zero_busy", 32'(busy_w[d]), 32'd0);
      chk("zero_done", 32'(done_w[d]), 32'd0);
      chk("zero_pass", 32'(pass_w[d]), 32'd0);
      chk("zero_err", 32'(err_w[d]), 32'd0);
      chk("zero_fidx", 32'(fidx_w[d]), 32'd0);
      chk("zero_fres", fres_w[d], 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_w[d] = 1'b0; fm_en[d] = 1'b0; fm_k[d] = 0; fm_val[d] = 32'd0; man_on[d] = 1'b0;
      end
      #12;
      for (int d = 0; d < 3; d++) chk_zero(d);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // clean run
      push(0, 1'b1, 5'd0, 4'd0, 32'd0, 30);
      pulse_start(0);
      wait_done(0, 100);

      // fault on vector 6, run continues to the end
      fm_en[0] = 1'b1; fm_k[0] = 6; fm_val[0] = 32'd0;
      push(0, 1'b0, 5'd1, 4'd6, 32'd0, 30);
      pulse_start(0);
      wait_done(0, 100);

      // restart from DONE with an error; start during vector 4 is ignored
      fm_en[0] = 1'b0;
      push(0, 1'b1, 5'd0, 4'd0, 32'd0, 30);
      pulse_start(0);
      wait_vec(0, 4, 50);
      pulse_start(0);
      wait_done(0, 100);

      // asynchronous reset during vector 9 of a faulted run
      fm_en[0] = 1'b1; fm_k[0] = 6; fm_val[0] = 32'd0;
      pulse_start(0);
      wait_vec(0, 9, 60);
      chk("err_before_reset", 32'(err_w[0]), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero(0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      fm_en[0] = 1'b0;
      @(posedge clk); #1;
      push(0, 1'b1, 5'd0, 4'd0, 32'd0, 30);
      pulse_start(0);
      wait_done(0, 100);

      // stop on first failure at vector 2
      fm_en[1] = 1'b1; fm_k[1] = 2; fm_val[1] = 32'hDEAD_BEEF;
      push(1, 1'b0, 5'd1, 4'd2, 32'hDEAD_BEEF, 6);
      pulse_start(1);
      wait_done(1, 50);
      chk("stop_held_op1", op1_w[1], 32'd15);
      chk("stop_held_ctrl", 32'(ctrl_w[1]), 32'(C_AND));

      // settle window of 3: wrong result for the first three cycles of vector 7 must be ignored
      push(2, 1'b1, 5'd0, 4'd0, 32'd0, 60);
      pulse_start(2);
      wait_vec(2, 7, 100);
      man_on[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("settle_ctrl_sra", 32'(ctrl_w[2]), 32'(C_SRA));
         chk("settle_op1", op1_w[2], 32'hFFFF_FFD0);
         @(posedge clk); #1;
      end
      man_on[2] = 1'b0;
      chk("settle_ctrl_sra_check", 32'(ctrl_w[2]), 32'(C_SRA));
      chk("settle_op1_check", op1_w[2], 32'hFFFF_FFD0);
      chk("settle_busy_check", 32'(busy_w[2]), 32'd1);
      wait_done(2, 100);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
